lsu: RTL and testbench

- Load/store unit between the core's execute stage and the byte-addressed data memory port (addr, w_data, fmt, r_en, w_en, r_data).
- Accepts one load/store request at a time.
- Aligned accesses go to memory as a single native access.
- Misaligned accesses are split into byte-serial accesses, the result is assembled, and the final sign/zero extension is applied. Faults on illegal funct3 and on disallowed misalignment.

---
 rtl/lake_pkg.sv | 24 ++
 rtl/lsu_extend.sv | 22 ++
 rtl/lsu.sv | 153 +++++++++++++++
 tb/tb_lsu.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lake_pkg.sv
// Shared constants and types for the load/store unit.
package lake_pkg;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Memory port access formats
  localparam logic [2:0] FMT_BYTE = 3'b000;
  localparam logic [2:0] FMT_HALF = 3'b001;
  localparam logic [2:0] FMT_WORD = 3'b010;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

  // Stores only exist for 000..010; loads additionally allow 100/101.
  function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
    if (we) return f3[2] | (f3[1] & f3[0]);
    else    return (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Final sign/zero extension of the assembled load value, selected by funct3.
module lsu_extend
  import lake_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  // Byte/half loads take only the low bits; word loads pass through
  always_comb begin
    data_o = data_i;
    case (funct3_i)
      F3_B:    data_o = {{24{data_i[7]}}, data_i[7:0]};
      F3_H:    data_o = {{16{data_i[15]}}, data_i[15:0]};
      F3_BU:   data_o = {24'h0, data_i[7:0]};
      F3_HU:   data_o = {16'h0, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, aligned accesses go native,
// misaligned accesses are serialised into byte accesses and reassembled.
module lsu
  import lake_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_fault,
  output logic [31:0] o_rdata,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_w_data,
  output logic [2:0]  o_mem_fmt,
  output logic        o_mem_r_en,
  output logic        o_mem_w_en,
  input  logic [31:0] i_mem_r_data
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, asm_q, asm_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d, mis_q, mis_d, fault_q, fault_d;
  logic [1:0]  k_q, k_d, last_q, last_d;
  logic [1:0]  req_sm1;
  logic        req_mis, req_fault;
  logic [31:0] ext_data;

  lsu_extend u_ext (
    .funct3_i (f3_q),
    .data_i   (asm_q),
    .data_o   (ext_data)
  );

  // State and request registers; reset abandons any transfer in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
      k_q     <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      fault_q <= fault_d;
      k_q     <= k_d;
      last_q  <= last_d;
    end
  end

  // Next-state, request decode and all outputs; enables are killed during reset
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    f3_d    = f3_q;
    we_d    = we_q;
    mis_d   = mis_q;
    fault_d = fault_q;
    k_d     = k_q;
    last_d  = last_q;

    // size-1 mask: byte 0, half 1, word 3
    case (i_req_funct3[1:0])
      2'b00:   req_sm1 = 2'd0;
      2'b01:   req_sm1 = 2'd1;
      default: req_sm1 = 2'd3;
    endcase
    req_mis   = |(i_req_addr[1:0] & req_sm1);
    req_fault = illegal_f3(i_req_we, i_req_funct3) | (req_mis & !ALLOW_MISALIGNED);

    o_ready      = 1'b0;
    o_done       = 1'b0;
    o_fault      = 1'b0;
    o_rdata      = '0;
    o_mem_addr   = '0;
    o_mem_w_data = '0;
    o_mem_fmt    = FMT_BYTE;
    o_mem_r_en   = 1'b0;
    o_mem_w_en   = 1'b0;

    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_req_valid) begin
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          f3_d    = i_req_funct3;
          we_d    = i_req_we;
          mis_d   = req_mis;
          fault_d = req_fault;
          asm_d   = '0;
          k_d     = '0;
          last_d  = req_mis ? req_sm1 : 2'd0;
          state_d = req_fault ? DONE : XFER;
        end
      end
      XFER: begin
        o_mem_r_en = !we_q;
        o_mem_w_en = we_q;
        if (mis_q) begin
          o_mem_addr = addr_q + {30'h0, k_q};
          o_mem_fmt  = FMT_BYTE;
          if (we_q) o_mem_w_data = {24'h0, wdata_q[{k_q, 3'b000} +: 8]};
          else      asm_d[{k_q, 3'b000} +: 8] = i_mem_r_data[7:0];
        end else begin
          o_mem_addr = addr_q;
          o_mem_fmt  = {1'b0, f3_q[1:0]};
          if (we_q) o_mem_w_data = wdata_q;
          else      asm_d = i_mem_r_data;
        end
        k_d = k_q + 2'd1;
        if (k_q == last_q) state_d = DONE;
      end
      DONE: begin
        o_done  = 1'b1;
        o_fault = fault_q;
        if (!fault_q && !we_q) o_rdata = ext_data;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (i_rst) begin
      o_ready    = 1'b0;
      o_done     = 1'b0;
      o_fault    = 1'b0;
      o_rdata    = '0;
      o_mem_r_en = 1'b0;
      o_mem_w_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: a byte-array memory model, a scoreboard of expected
// completions, a table of load/store vectors and hand-written corner cases.
module tb_lsu;

  logic clk, rst, mem_clr;
  int   cyc;
  int   n_chk, n_pass;

  // DUT with misaligned splitting
  logic        req_valid, req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr, req_wdata;
  logic        ready1, done1, fault1, mren1, mwen1;
  logic [31:0] rdata1, maddr1, mwdata1, mrdata1;
  logic [2:0]  mfmt1;

  // DUT that faults on misalignment (never connected to real memory)
  logic        v0, we0;
  logic [2:0]  f30;
  logic [31:0] addr0;
  logic        ready0, done0, fault0, mren0, mwen0;
  logic [31:0] rdata0, maddr0, mwdata0;
  logic [2:0]  mfmt0;
  int          bad0;

  lsu #(.ALLOW_MISALIGNED(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_we(req_we),
    .i_req_funct3(req_f3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_ready(ready1), .o_done(done1), .o_fault(fault1), .o_rdata(rdata1),
    .o_mem_addr(maddr1), .o_mem_w_data(mwdata1), .o_mem_fmt(mfmt1),
    .o_mem_r_en(mren1), .o_mem_w_en(mwen1), .i_mem_r_data(mrdata1));

  lsu #(.ALLOW_MISALIGNED(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(v0), .i_req_we(we0),
    .i_req_funct3(f30), .i_req_addr(addr0), .i_req_wdata(32'h0),
    .o_ready(ready0), .o_done(done0), .o_fault(fault0), .o_rdata(rdata0),
    .o_mem_addr(maddr0), .o_mem_w_data(mwdata0), .o_mem_fmt(mfmt0),
    .o_mem_r_en(mren0), .o_mem_w_en(mwen0), .i_mem_r_data(32'h0));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [7:0] mem [256];
  logic [7:0] ma0, ma1, ma2, ma3;

  always_comb begin
    ma0 = maddr1[7:0];
    ma1 = ma0 + 8'd1;
    ma2 = ma0 + 8'd2;
    ma3 = ma0 + 8'd3;
    case (mfmt1)
      3'b000:  mrdata1 = {{24{mem[ma0][7]}}, mem[ma0]};
      3'b001:  mrdata1 = {{16{mem[ma1][7]}}, mem[ma1], mem[ma0]};
      default: mrdata1 = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10] <= 8'h80;
      mem[8'h11] <= 8'h7F;
      mem[8'h12] <= 8'h01;
      mem[8'h13] <= 8'hFF;
    end else if (mwen1) begin
      mem[ma0] <= mwdata1[7:0];
      if (mfmt1 != 3'b000) mem[ma1] <= mwdata1[15:8];
      if (mfmt1 == 3'b010) begin
        mem[ma2] <= mwdata1[23:16];
        mem[ma3] <= mwdata1[31:24];
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          t0;
    int          lat;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  typedef struct {
    int          c;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  fmt;
    logic [7:0]  wb;
  } acc_t;
  acc_t alog[$];

  // Record memory accesses and score completions away from the active edge
  always @(negedge clk) begin
    if (mren1 || mwen1)
      alog.push_back('{cyc, mwen1, maddr1, mfmt1, mwdata1[7:0]});
    if (mren0 || mwen0) bad0++;
    if (done1) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("rdata", rdata1, e.rdata);
        chk("fault", {31'h0, fault1}, {31'h0, e.fault});
        chk("latency", cyc - e.t0, e.lat);
      end
    end
  end

  // Wait for ready, present one request for one cycle, optionally score it
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_f, input int lat, input bit push,
                       output int t);
    int w;
    w = 0;
    @(negedge clk);
    while (!ready1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ready1) chk("ready_timeout", 32'd0, 32'd1);
    #1;
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
    t = cyc;
    if (push) sb.push_back('{exp_rd, exp_f, t, lat});
    @(negedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  // Fault-only request on the no-misalign instance
  task automatic issue0(input logic we, input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    chk("dut0_ready", {31'h0, ready0}, 32'd1);
    #1;
    v0 = 1'b1; we0 = we; f30 = f3; addr0 = a;
    @(negedge clk);
    chk("dut0_done", {31'h0, done0}, 32'd1);
    chk("dut0_fault", {31'h0, fault0}, 32'd1);
    chk("dut0_rdata", rdata0, 32'h0);
    #1 v0 = 1'b0;
    @(negedge clk);
    chk("dut0_done_once", {31'h0, done0}, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_f;
    int          nacc;
  } vec_t;
  vec_t tv[16];

  initial begin
    int t, lat;
    logic [2:0] efmt;

    n_chk = 0; n_pass = 0; bad0 = 0;
    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'b0; req_addr = '0; req_wdata = '0;
    v0 = 1'b0; we0 = 1'b0; f30 = 3'b0; addr0 = '0;

    //            we    f3      addr    wdata         exp_rd        fault nacc
    tv[0]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hFF017F80, 1'b0, 1};
    tv[1]  = '{1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFF80, 1'b0, 1};
    tv[2]  = '{1'b0, 3'b100, 32'h10, 32'h0,        32'h00000080, 1'b0, 1};
    tv[3]  = '{1'b0, 3'b101, 32'h12, 32'h0,        32'h0000FF01, 1'b0, 1};
    tv[4]  = '{1'b0, 3'b001, 32'h11, 32'h0,        32'h0000017F, 1'b0, 2};
    tv[5]  = '{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFFF01, 1'b0, 1};
    tv[6]  = '{1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1, 0};
    tv[7]  = '{1'b1, 3'b011, 32'h10, 32'h12345678, 32'h0,        1'b1, 0};
    tv[8]  = '{1'b1, 3'b000, 32'h14, 32'h123456AA, 32'h0,        1'b0, 1};
    tv[9]  = '{1'b0, 3'b100, 32'h14, 32'h0,        32'h000000AA, 1'b0, 1};
    tv[10] = '{1'b0, 3'b010, 32'h13, 32'h0,        32'h0000AAFF, 1'b0, 4};
    tv[11] = '{1'b0, 3'b101, 32'h11, 32'h0,        32'h0000017F, 1'b0, 2};
    tv[12] = '{1'b0, 3'b110, 32'h10, 32'h0,        32'h0,        1'b1, 0};
    tv[13] = '{1'b1, 3'b001, 32'h17, 32'h0000BEEF, 32'h0,        1'b0, 2};
    tv[14] = '{1'b0, 3'b001, 32'h17, 32'h0,        32'hFFFFBEEF, 1'b0, 2};
    tv[15] = '{1'b1, 3'b111, 32'h20, 32'hFFFFFFFF, 32'h0,        1'b1, 0};

    // Reset behaviour
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, ready1}, 32'd0);
    chk("rst_ren", {31'h0, mren1}, 32'd0);
    chk("rst_wen", {31'h0, mwen1}, 32'd0);
    #1 rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'h0, ready1}, 32'd1);
    chk("idle_done", {31'h0, done1}, 32'd0);
    chk("idle_rdata", rdata1, 32'h0);
    chk("idle_maddr", maddr1, 32'h0);

    // Table of vectors
    for (int i = 0; i < 16; i++) begin
      lat  = tv[i].exp_f ? 1 : tv[i].nacc + 1;
      efmt = (tv[i].nacc == 1) ? {1'b0, tv[i].f3[1:0]} : 3'b000;
      alog.delete();
      issue(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, tv[i].exp_rd, tv[i].exp_f, lat, 1'b1, t);
      wait_idle();
      chk($sformatf("v%0d_nacc", i), alog.size(), tv[i].nacc);
      if (tv[i].nacc > 0) begin
        chk($sformatf("v%0d_addr", i), alog[0].addr, tv[i].addr);
        chk($sformatf("v%0d_fmt", i), {29'h0, alog[0].fmt}, {29'h0, efmt});
        chk($sformatf("v%0d_acc_cyc", i), alog[0].c, t + 1);
        chk($sformatf("v%0d_we", i), {31'h0, alog[0].we}, {31'h0, tv[i].we});
      end
    end

    // Misaligned word store, byte-serial trace, then read back across it
    alog.delete();
    issue(1'b1, 3'b010, 32'h21, 32'hDEADBEEF, 32'h0, 1'b0, 5, 1'b1, t);
    wait_idle();
    chk("sw_nacc", alog.size(), 4);
    if (alog.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("sw_addr%0d", i), alog[i].addr, 32'h21 + i);
        chk($sformatf("sw_byte%0d", i), {24'h0, alog[i].wb}, {24'h0, 32'hDEADBEEF >> (8 * i)} & 32'hFF);
        chk($sformatf("sw_cyc%0d", i), alog[i].c, t + 1 + i);
        chk($sformatf("sw_fmt%0d", i), {29'h0, alog[i].fmt}, 32'h0);
      end
    end
    issue(1'b0, 3'b010, 32'h20, 32'h0, 32'hADBEEF00, 1'b0, 2, 1'b1, t);
    wait_idle();

    // Misalignment disallowed, and an illegal load, on the second instance
    issue0(1'b0, 3'b010, 32'h02);
    issue0(1'b0, 3'b011, 32'h04);

    // Reset during the second byte of a misaligned store
    alog.delete();
    issue(1'b1, 3'b010, 32'h31, 32'h11223344, 32'h0, 1'b0, 0, 1'b0, t);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rstmid_wen", {31'h0, mwen1}, 32'd0);
    chk("rstmid_ren", {31'h0, mren1}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_ready", {31'h0, ready1}, 32'd1);
    repeat (6) @(negedge clk);
    chk("rstmid_nacc", alog.size(), 1);
    if (alog.size() > 0) begin
      chk("rstmid_addr", alog[0].addr, 32'h31);
      chk("rstmid_cyc", alog[0].c, t + 1);
    end
    chk("rstmid_mem31", {24'h0, mem[8'h31]}, 32'h44);
    chk("rstmid_mem32", {24'h0, mem[8'h32]}, 32'h00);

    chk("dut0_no_mem", bad0, 0);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
